text_vram_arbiter: RTL and testbench

//  Shares one single-port synchronous text RAM (char codes) between the HDMI/VGA scan-out fetcher and a host writer.

---
 rtl/text_vram_pkg.sv | 14 +
 rtl/text_vram_arbiter_if.sv | 48 ++++
 rtl/text_vram_wfifo.sv | 41 ++++
 rtl/text_vram_arbiter.sv | 109 ++++++++++
 tb/tb_text_vram_arbiter.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/text_vram_pkg.sv
// Shared constants and types for the text VRAM arbiter.
package text_vram_pkg;
  localparam int TV_AW         = 12;
  localparam int TV_DW         = 8;
  localparam int TV_CELLS      = 2400;
  localparam int TV_FIFO_DEPTH = 4;

  typedef enum logic [1:0] {IDLE, DRAIN, CLEAR} state_t;

  typedef struct packed {
    logic [TV_AW-1:0] addr;
    logic [TV_DW-1:0] data;
  } wr_entry_t;
endpackage

// File: rtl/text_vram_arbiter_if.sv
// Display, host and RAM-side signals of the text VRAM arbiter.
// HOST_READ_EN adds the host read channel.
interface text_vram_arbiter_if #(parameter int AW = 12, parameter int DW = 8);
  logic          disp_req;
  logic [AW-1:0] disp_addr;
  logic          disp_valid;
  logic [DW-1:0] disp_data;
  logic          wr_valid;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          clr_start;
  logic [DW-1:0] clr_char;
  logic          busy;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;
`ifdef HOST_READ_EN
  logic          rd_valid;
  logic [AW-1:0] rd_addr;
  logic          rd_ready;
  logic          rd_dvalid;
  logic [DW-1:0] rd_data;

  modport master (
    output disp_req, disp_addr, wr_valid, wr_addr, wr_data, clr_start, clr_char, ram_rdata,
           rd_valid, rd_addr,
    input  disp_valid, disp_data, wr_ready, busy, ram_addr, ram_we, ram_wdata,
           rd_ready, rd_dvalid, rd_data
  );
  modport slave (
    input  disp_req, disp_addr, wr_valid, wr_addr, wr_data, clr_start, clr_char, ram_rdata,
           rd_valid, rd_addr,
    output disp_valid, disp_data, wr_ready, busy, ram_addr, ram_we, ram_wdata,
           rd_ready, rd_dvalid, rd_data
  );
`else
  modport master (
    output disp_req, disp_addr, wr_valid, wr_addr, wr_data, clr_start, clr_char, ram_rdata,
    input  disp_valid, disp_data, wr_ready, busy, ram_addr, ram_we, ram_wdata
  );
  modport slave (
    input  disp_req, disp_addr, wr_valid, wr_addr, wr_data, clr_start, clr_char, ram_rdata,
    output disp_valid, disp_data, wr_ready, busy, ram_addr, ram_we, ram_wdata
  );
`endif
endinterface

// File: rtl/text_vram_wfifo.sv
// Host write queue: synchronous FIFO of packed {addr,data} entries.
module text_vram_wfifo #(
  parameter int W     = 20,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wp, rp;
  logic [PW:0]   cnt;

  always_ff @(posedge clk)
    if (push) mem[wp] <= din;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push) wp <= wp + PW'(1);
      if (pop)  rp <= rp + PW'(1);
      cnt <= cnt + (PW+1)'(push) - (PW+1)'(pop);
    end
  end

  assign dout  = mem[rp];
  assign full  = (cnt == (PW+1)'(DEPTH));
  assign empty = (cnt == '0);
  assign count = cnt;
endmodule

// File: rtl/text_vram_arbiter.sv
// Single-port text RAM arbiter: display reads always win, queued host writes and
// the clear-screen fill use the leftover slots. HOST_READ_EN adds a host read port.
module text_vram_arbiter
  import text_vram_pkg::*;
#(
  parameter int AW         = TV_AW,
  parameter int DW         = TV_DW,
  parameter int CELLS      = TV_CELLS,
  parameter int FIFO_DEPTH = TV_FIFO_DEPTH
) (
  input logic clk,
  input logic rst,
  text_vram_arbiter_if.slave bus
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_t           state;
  logic [AW-1:0]    clr_cnt;
  logic [DW-1:0]    clr_chr;
  logic             wr_rdy, disp_vld;
  logic             push, pop, clr_wr, rd_go, full, empty, full_nx;
  logic [CW-1:0]    fcnt, fcnt_nx;
  logic [AW+DW-1:0] head;

  text_vram_wfifo #(.W(AW+DW), .DEPTH(FIFO_DEPTH)) u_wfifo (
    .clk(clk), .rst(rst), .push(push), .pop(pop),
    .din({bus.wr_addr, bus.wr_data}), .dout(head),
    .full(full), .empty(empty), .count(fcnt)
  );

`ifdef HOST_READ_EN
  logic rd_vld;
  // Host reads only go out with nothing queued, so they never overtake a write.
  assign bus.rd_ready  = (state == IDLE) && empty && !bus.disp_req;
  assign rd_go         = bus.rd_valid && bus.rd_ready;
  assign bus.rd_dvalid = rd_vld;
  assign bus.rd_data   = bus.ram_rdata;
  always_ff @(posedge clk or posedge rst)
    if (rst) rd_vld <= 1'b0;
    else     rd_vld <= rd_go;
`else
  assign rd_go = 1'b0;
`endif

  assign push    = bus.wr_valid && wr_rdy && !full;
  assign pop     = !bus.disp_req && !rd_go && !empty && (state != CLEAR);
  assign clr_wr  = !bus.disp_req && (state == CLEAR);
  assign fcnt_nx = fcnt + CW'(push) - CW'(pop);
  assign full_nx = (fcnt_nx == CW'(FIFO_DEPTH));

  always_comb begin
    bus.ram_addr  = bus.disp_addr;
    bus.ram_we    = 1'b0;
    bus.ram_wdata = head[DW-1:0];
`ifdef HOST_READ_EN
    if (rd_go) bus.ram_addr = bus.rd_addr;
`endif
    if (pop) begin
      bus.ram_addr = head[AW+DW-1:DW];
      bus.ram_we   = 1'b1;
    end
    if (clr_wr) begin
      bus.ram_addr  = clr_cnt;
      bus.ram_wdata = clr_chr;
      bus.ram_we    = 1'b1;
    end
  end

  // wr_ready drops on clr_start acceptance so nothing can slip in behind the clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      clr_cnt <= '0;
      clr_chr <= '0;
      wr_rdy  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          wr_rdy <= !full_nx;
          if (bus.clr_start) begin
            clr_chr <= bus.clr_char;
            wr_rdy  <= 1'b0;
            state   <= (fcnt_nx != '0) ? DRAIN : CLEAR;
          end
        end
        DRAIN: if (fcnt_nx == '0) state <= CLEAR;
        CLEAR: if (clr_wr) begin
          if (clr_cnt == AW'(CELLS - 1)) begin
            state   <= IDLE;
            clr_cnt <= '0;
            wr_rdy  <= 1'b1;
          end else begin
            clr_cnt <= clr_cnt + AW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) disp_vld <= 1'b0;
    else     disp_vld <= bus.disp_req;

  assign bus.disp_valid = disp_vld;
  assign bus.disp_data  = bus.ram_rdata;
  assign bus.wr_ready   = wr_rdy;
  assign bus.busy       = (state != IDLE);
endmodule

// File: tb/tb_text_vram_arbiter.sv
// Bench for text_vram_arbiter: cycle vector table, corner sequences and a random phase,
// all checked by a queue-based model of the write stream and RAM contents.
module tb_text_vram_arbiter;
  import text_vram_pkg::*;
  localparam int AW = TV_AW, DW = TV_DW, CELLS = TV_CELLS, DEPTH = TV_FIFO_DEPTH;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  text_vram_arbiter_if #(.AW(AW), .DW(DW)) bus();
  text_vram_arbiter #(.AW(AW), .DW(DW), .CELLS(CELLS), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  // RAM macro stand-in, read-first, one cycle latency
  bit [DW-1:0] ram [2**AW];
  always @(posedge clk) begin
    if (bus.ram_we) ram[bus.ram_addr] <= bus.ram_wdata;
    bus.ram_rdata <= ram[bus.ram_addr];
  end

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: pending host writes, then the clear stream; contents tracked per cell.
  wr_entry_t   wq[$];
  bit          clr_act;
  bit [DW-1:0] clr_ch_m;
  int          clr_idx;
  bit          exp_dv;
  bit [DW-1:0] exp_dd;
  bit [DW-1:0] mem_m [2**AW];
  logic        rst_seen;

  always @(posedge clk) rst_seen <= rst;

  always @(negedge clk) begin
    wr_entry_t e;
    bit        act0;
    if (rst) begin
      wq.delete();
      clr_act = 1'b0;
      exp_dv  = 1'b0;
    end else if (rst_seen === 1'b0) begin
      act0 = clr_act;
      chk("busy", 32'(bus.busy), 32'(clr_act));
      chk("wr_ready", 32'(bus.wr_ready), 32'(!clr_act && wq.size() < DEPTH));
      chk("disp_valid", 32'(bus.disp_valid), 32'(exp_dv));
      if (exp_dv) chk("disp_data", 32'(bus.disp_data), 32'(exp_dd));
      exp_dv = bus.disp_req;
      if (bus.disp_req) begin
        chk("disp_no_we", 32'(bus.ram_we), 0);
        chk("disp_ram_addr", 32'(bus.ram_addr), 32'(bus.disp_addr));
        exp_dd = mem_m[bus.disp_addr];
      end else if (wq.size() > 0 || clr_act) begin
        chk("free_slot_we", 32'(bus.ram_we), 1);
        if (bus.ram_we) begin
          if (wq.size() > 0) e = wq.pop_front();
          else begin
            e.addr = AW'(clr_idx);
            e.data = clr_ch_m;
            clr_idx++;
            if (clr_idx == CELLS) clr_act = 1'b0;
          end
          chk("wr_addr", 32'(bus.ram_addr), 32'(e.addr));
          chk("wr_data", 32'(bus.ram_wdata), 32'(e.data));
          mem_m[e.addr] = e.data;
        end
      end else begin
        chk("idle_no_we", 32'(bus.ram_we), 0);
      end
      if (bus.wr_valid && bus.wr_ready) begin
        e.addr = bus.wr_addr;
        e.data = bus.wr_data;
        wq.push_back(e);
      end
      if (bus.clr_start && !act0) begin
        clr_act  = 1'b1;
        clr_ch_m = bus.clr_char;
        clr_idx  = 0;
      end
    end
  end

  typedef struct {
    logic dreq; logic [AW-1:0] daddr;
    logic wv;   logic [AW-1:0] waddr; logic [DW-1:0] wdata;
    logic e_we; logic [AW-1:0] e_addr; logic [DW-1:0] e_wdata;
    logic e_dv; logic [DW-1:0] e_dd; logic e_wr;
  } vec_t;
  vec_t tbl[10];

  task automatic idle_in();
    bus.disp_req = 1'b0; bus.disp_addr = '0; bus.wr_valid = 1'b0;
    bus.wr_addr = '0; bus.wr_data = '0; bus.clr_start = 1'b0; bus.clr_char = '0;
`ifdef HOST_READ_EN
    bus.rd_valid = 1'b0; bus.rd_addr = '0;
`endif
  endtask

  task automatic start_clear(input logic [DW-1:0] ch);
    @(posedge clk); #1;
    idle_in();
    bus.clr_start = 1'b1; bus.clr_char = ch;
    @(posedge clk); #1;
    bus.clr_start = 1'b0; bus.clr_char = 8'hEE;
  endtask

  initial begin
    int n, w, bc, st, cyc;
    tbl[0] = '{1'b0, 12'd0,  1'b1, 12'd5,  8'h41, 1'b0, 12'd0,  8'h00, 1'b0, 8'h00, 1'b1};
    tbl[1] = '{1'b1, 12'd5,  1'b0, 12'd0,  8'h00, 1'b0, 12'd5,  8'h00, 1'b0, 8'h00, 1'b1};
    tbl[2] = '{1'b0, 12'd0,  1'b0, 12'd0,  8'h00, 1'b1, 12'd5,  8'h41, 1'b1, 8'h00, 1'b1};
    tbl[3] = '{1'b1, 12'd5,  1'b0, 12'd0,  8'h00, 1'b0, 12'd5,  8'h00, 1'b0, 8'h00, 1'b1};
    tbl[4] = '{1'b0, 12'd0,  1'b0, 12'd0,  8'h00, 1'b0, 12'd0,  8'h00, 1'b1, 8'h41, 1'b1};
    tbl[5] = '{1'b1, 12'h10, 1'b1, 12'h10, 8'h99, 1'b0, 12'h10, 8'h00, 1'b0, 8'h00, 1'b1};
    tbl[6] = '{1'b1, 12'h10, 1'b0, 12'd0,  8'h00, 1'b0, 12'h10, 8'h00, 1'b1, 8'h00, 1'b1};
    tbl[7] = '{1'b0, 12'd0,  1'b0, 12'd0,  8'h00, 1'b1, 12'h10, 8'h99, 1'b1, 8'h00, 1'b1};
    tbl[8] = '{1'b1, 12'h10, 1'b0, 12'd0,  8'h00, 1'b0, 12'h10, 8'h00, 1'b0, 8'h00, 1'b1};
    tbl[9] = '{1'b0, 12'd0,  1'b0, 12'd0,  8'h00, 1'b0, 12'd0,  8'h00, 1'b1, 8'h99, 1'b1};

    idle_in();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_disp_valid", 32'(bus.disp_valid), 0);
    chk("rst_wr_ready", 32'(bus.wr_ready), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_ram_we", 32'(bus.ram_we), 0);
    @(posedge clk); #1 rst = 1'b0;

    // Basic write / display vectors
    foreach (tbl[i]) begin
      @(posedge clk); #1;
      bus.disp_req = tbl[i].dreq; bus.disp_addr = tbl[i].daddr;
      bus.wr_valid = tbl[i].wv; bus.wr_addr = tbl[i].waddr; bus.wr_data = tbl[i].wdata;
      @(negedge clk);
      chk($sformatf("v%0d_we", i), 32'(bus.ram_we), 32'(tbl[i].e_we));
      if (tbl[i].dreq || tbl[i].e_we) chk($sformatf("v%0d_addr", i), 32'(bus.ram_addr), 32'(tbl[i].e_addr));
      if (tbl[i].e_we) chk($sformatf("v%0d_wdata", i), 32'(bus.ram_wdata), 32'(tbl[i].e_wdata));
      chk($sformatf("v%0d_dvalid", i), 32'(bus.disp_valid), 32'(tbl[i].e_dv));
      if (tbl[i].e_dv) chk($sformatf("v%0d_ddata", i), 32'(bus.disp_data), 32'(tbl[i].e_dd));
      chk($sformatf("v%0d_wr_ready", i), 32'(bus.wr_ready), 32'(tbl[i].e_wr));
    end

    // Display hogs the RAM while the FIFO fills
    n = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      bus.disp_req = 1'b1; bus.disp_addr = AW'($urandom_range(0, 2047));
      bus.wr_valid = 1'b1; bus.wr_addr = AW'($urandom_range(0, 2047)); bus.wr_data = DW'($urandom);
      @(negedge clk);
      if (bus.wr_ready) n++;
    end
    chk("fill_accepts", 32'(n), 4);
    chk("fill_wr_ready", 32'(bus.wr_ready), 0);
    @(posedge clk); #1 idle_in();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("drain_back_to_back", 32'(bus.ram_we), 1);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("drain_done", 32'(bus.ram_we), 0);

    // Clear with two writes queued ahead of it
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      bus.disp_req = 1'b1; bus.disp_addr = 12'd3;
      bus.wr_valid = 1'b1; bus.wr_addr = AW'(100 + k); bus.wr_data = DW'(8'hA0 + k);
    end
    @(posedge clk); #1;
    bus.wr_valid = 1'b0; bus.clr_start = 1'b1; bus.clr_char = 8'h20;
    @(posedge clk); #1 idle_in();
    w = 0; cyc = 0;
    do begin
      @(negedge clk);
      if (bus.ram_we) w++;
      cyc++;
    end while (bus.busy && cyc < 4000);
    chk("clear_timeout", 32'(cyc < 4000), 1);
    chk("drain_plus_clear_writes", 32'(w), 32'(CELLS + 2));
    chk("clear_wr_ready_back", 32'(bus.wr_ready), 1);
    @(posedge clk); #1 bus.disp_req = 1'b1; bus.disp_addr = AW'(CELLS - 1);
    @(posedge clk); #1 bus.disp_addr = AW'(CELLS);
    @(negedge clk) chk("last_cell_cleared", 32'(bus.disp_data), 32'h20);
    @(posedge clk); #1 idle_in();
    @(negedge clk) chk("cell_past_end_untouched", 32'(bus.disp_data), 0);

    // Clear with a display read every 8th cycle
    start_clear(8'h31);
    w = 0; bc = 0; st = 0; cyc = 0;
    while (cyc < 5000) begin
      bus.disp_req = (cyc % 8 == 7); bus.disp_addr = AW'($urandom);
      @(negedge clk);
      if (!bus.busy) break;
      bc++;
      if (bus.disp_req) st++;
      if (bus.ram_we) w++;
      cyc++;
      @(posedge clk); #1;
    end
    chk("stall_clear_timeout", 32'(cyc < 5000), 1);
    chk("stall_clear_writes", 32'(w), 32'(CELLS));
    chk("stall_clear_cycles", 32'(bc), 32'(CELLS + st));
    chk("stall_clear_saw_stalls", 32'(st >= CELLS / 7), 1);

    // Reset in the middle of a clear
    start_clear(8'h55);
    w = 0; cyc = 0;
    while (w < 1000 && cyc < 3000) begin
      @(negedge clk);
      if (bus.ram_we) w++;
      cyc++;
      if (w < 1000) begin @(posedge clk); #1; end
    end
    chk("midclear_reached", 32'(w), 1000);
    @(posedge clk); #1 bus.disp_req = 1'b1; bus.disp_addr = 12'd7;
    @(posedge clk); #2 bus.disp_req = 1'b0; rst = 1'b1;
    #1;
    chk("midrst_busy", 32'(bus.busy), 0);
    chk("midrst_wr_ready", 32'(bus.wr_ready), 0);
    chk("midrst_disp_valid", 32'(bus.disp_valid), 0);
    chk("midrst_ram_we", 32'(bus.ram_we), 0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("postrst_busy", 32'(bus.busy), 0);
    chk("postrst_wr_ready", 32'(bus.wr_ready), 1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk) chk("postrst_fifo_empty", 32'(bus.ram_we), 0);
    end

`ifdef HOST_READ_EN
    @(posedge clk); #1 bus.wr_valid = 1'b1; bus.wr_addr = 12'd9; bus.wr_data = 8'h7E;
    @(posedge clk); #1 bus.wr_valid = 1'b0; bus.rd_valid = 1'b1; bus.rd_addr = 12'd9;
    @(negedge clk) chk("rd_ready_waits", 32'(bus.rd_ready), 0);
    @(negedge clk) chk("rd_ready", 32'(bus.rd_ready), 1);
    @(posedge clk); #1 bus.rd_valid = 1'b0;
    @(negedge clk);
    chk("rd_dvalid", 32'(bus.rd_dvalid), 1);
    chk("rd_data", 32'(bus.rd_data), 32'h7E);
`endif

    // Random traffic, occasional clear
    for (int k = 0; k < 600; k++) begin
      @(posedge clk); #1;
      bus.disp_req  = ($urandom_range(0, 2) == 0);
      bus.disp_addr = AW'($urandom);
      bus.wr_valid  = $urandom_range(0, 1);
      bus.wr_addr   = AW'($urandom);
      bus.wr_data   = DW'($urandom);
      bus.clr_start = ($urandom_range(0, 250) == 0);
      bus.clr_char  = DW'($urandom);
    end
    @(posedge clk); #1 idle_in();
    cyc = 0;
    do begin @(negedge clk); cyc++; end while ((bus.busy || wq.size() > 0) && cyc < 4000);
    chk("final_idle", 32'(cyc < 4000), 1);
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
